// File: rtl/buff_eject_sb_if.sv
// Flit bundle for buff_eject_sb: four directional input ports, four registered output ports and side-buffer access.
// The master drives incoming flits and sb_rd. The slave (the ejector) drives the outputs and the buffer status.
interface buff_eject_sb_if #(
  parameter int FLIT_W   = 11,
  parameter int SB_DEPTH = 4
);
  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  logic [FLIT_W-1:0] northad, southad, eastad, westad;
  logic              nv_in, sv_in, ev_in, wv_in;
  logic [FLIT_W-1:0] nad, sad, ead, wad;
  logic              nv, sv, ev, wv;
  logic              sb_rd;
  logic [FLIT_W-1:0] sbuff;
  logic              sb_empty, sb_full;
  logic [CNT_W-1:0]  sb_count;

  modport master (
    output northad, southad, eastad, westad,
    output nv_in, sv_in, ev_in, wv_in,
    output sb_rd,
    input  nad, sad, ead, wad,
    input  nv, sv, ev, wv,
    input  sbuff, sb_empty, sb_full, sb_count
  );

  modport slave (
    input  northad, southad, eastad, westad,
    input  nv_in, sv_in, ev_in, wv_in,
    input  sb_rd,
    output nad, sad, ead, wad,
    output nv, sv, ev, wv,
    output sbuff, sb_empty, sb_full, sb_count
  );
endinterface

// File: rtl/buff_eject_sb.sv
// Ejects at most one eligible flit per cycle into a side-buffer FIFO and registers the other ports with a cleared direction field.
// Define BUFF_EJECT_LFSR_EN to take the scan start index from an 8-bit LFSR instead of the round-robin pointer.
module buff_eject_sb #(
  parameter int FLIT_W   = 11,
  parameter int DIR_LSB  = 6,
  parameter int SB_DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  buff_eject_sb_if.slave bus
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SB_DEPTH);

  typedef enum logic [1:0] {
    PORT_N = 2'd0,
    PORT_S = 2'd1,
    PORT_E = 2'd2,
    PORT_W = 2'd3
  } port_e;

  // A flit is not ejected from the port whose direction code this is.
  function automatic logic [2:0] excl_code(input logic [1:0] p);
    case (p)
      PORT_N:  excl_code = 3'b010;
      PORT_S:  excl_code = 3'b011;
      PORT_E:  excl_code = 3'b000;
      default: excl_code = 3'b001;
    endcase
  endfunction

  function automatic logic [FLIT_W-1:0] clr_dir(input logic [FLIT_W-1:0] f);
    logic [FLIT_W-1:0] r;
    r = f;
    r[DIR_LSB +: 3] = 3'b000;
    return r;
  endfunction

  logic [FLIT_W-1:0] in_flit [4];
  logic [3:0]        in_v;
  logic [3:0]        elig;
  logic [1:0]        sel_start;
  logic [1:0]        sel;
  logic [1:0]        scan_idx;
  logic              found;
  logic              push_ok;
  logic              eject;
  logic              pop;

  logic [FLIT_W-1:0] out_ad [4];
  logic [3:0]        out_v;

  logic [FLIT_W-1:0] mem [SB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  always_comb begin
    in_flit[0] = bus.northad;
    in_flit[1] = bus.southad;
    in_flit[2] = bus.eastad;
    in_flit[3] = bus.westad;
    in_v       = {bus.wv_in, bus.ev_in, bus.sv_in, bus.nv_in};
  end

  always_comb begin
    elig = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      elig[p] = in_v[p] && (in_flit[p][DIR_LSB +: 3] != excl_code(2'(p)));
    end
  end

  // The first eligible port at or after sel_start wins, wrapping N,S,E,W.
  always_comb begin
    sel      = sel_start;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      scan_idx = sel_start + 2'(k);
      if (!found && elig[scan_idx]) begin
        sel   = scan_idx;
        found = 1'b1;
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  // When the buffer is full, a same-cycle pop frees the slot that the push needs.
  assign push_ok = !full || bus.sb_rd;
  assign eject   = found && push_ok;
  assign pop     = bus.sb_rd && !empty;

`ifdef BUFF_EJECT_LFSR_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'h01;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign sel_start = lfsr[1:0];
`else
  logic [1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (eject) begin
      rr_ptr <= sel + 2'd1;
    end
  end

  assign sel_start = rr_ptr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < 4; p++) begin
        out_ad[p] <= '0;
      end
      out_v <= '0;
    end else begin
      for (int unsigned p = 0; p < 4; p++) begin
        if (eject && (sel == 2'(p))) begin
          out_ad[p] <= '0;
          out_v[p]  <= 1'b0;
        end else begin
          out_ad[p] <= in_v[p] ? clr_dir(in_flit[p]) : '0;
          out_v[p]  <= in_v[p];
        end
      end
    end
  end

  // The pointers wrap naturally because SB_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (eject) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({eject, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // The storage has no reset. Buffered flits are discarded by resetting the pointers.
  always_ff @(posedge clk) begin
    if (eject) mem[wr_ptr] <= clr_dir(in_flit[sel]);
  end

  assign bus.nad      = out_ad[0];
  assign bus.sad      = out_ad[1];
  assign bus.ead      = out_ad[2];
  assign bus.wad      = out_ad[3];
  assign bus.nv       = out_v[0];
  assign bus.sv       = out_v[1];
  assign bus.ev       = out_v[2];
  assign bus.wv       = out_v[3];
  assign bus.sbuff    = empty ? '0 : mem[rd_ptr];
  assign bus.sb_empty = empty;
  assign bus.sb_full  = full;
  assign bus.sb_count = count;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CNT_FULL);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) (full && !bus.sb_rd) |-> !eject);
  a_sel_elig:    assert property (@(posedge clk) disable iff (!rst_n) eject |-> elig[sel]);
endmodule

// File: tb/tb_buff_eject_sb.sv
// Testbench for buff_eject_sb in the default round-robin build.
// A queue holds the expected side-buffer contents, which are compared as the DUT pops them.
module tb_buff_eject_sb;
  localparam int FW = 11;
  localparam int DL = 6;
  localparam int SD = 4;
  localparam int CW = $clog2(SD) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  buff_eject_sb_if #(.FLIT_W(FW), .SB_DEPTH(SD)) bus ();

  buff_eject_sb #(.FLIT_W(FW), .DIR_LSB(DL), .SB_DEPTH(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [FW-1:0] o_ad [4];
  logic          o_v  [4];
  assign o_ad[0] = bus.nad;
  assign o_ad[1] = bus.sad;
  assign o_ad[2] = bus.ead;
  assign o_ad[3] = bus.wad;
  assign o_v[0]  = bus.nv;
  assign o_v[1]  = bus.sv;
  assign o_v[2]  = bus.ev;
  assign o_v[3]  = bus.wv;

  logic [FW-1:0] in_ad  [4];
  logic          in_v   [4];
  logic          in_rd;
  logic [FW-1:0] exp_ad [4];
  logic          exp_v  [4];
  logic [FW-1:0] sbq    [$];
  int            m_rr;
  int            exp_sel;

  function automatic logic [2:0] excl(input int p);
    case (p)
      0:       return 3'b010;
      1:       return 3'b011;
      2:       return 3'b000;
      default: return 3'b001;
    endcase
  endfunction

  // The flit layout is payload[7:6], dir[2:0], payload[5:0].
  function automatic logic [FW-1:0] mk(input logic [2:0] dir, input logic [7:0] pl);
    return {pl[7:6], dir, pl[5:0]};
  endfunction

  function automatic logic [FW-1:0] nodir(input logic [FW-1:0] f);
    logic [FW-1:0] r;
    r = f;
    r[DL +: 3] = 3'b000;
    return r;
  endfunction

  task automatic set_in(input logic [FW-1:0] a0, a1, a2, a3, input logic [3:0] v, input logic rd);
    in_ad[0] = a0; in_ad[1] = a1; in_ad[2] = a2; in_ad[3] = a3;
    for (int p = 0; p < 4; p++) in_v[p] = v[p];
    in_rd = rd;
    bus.northad = a0; bus.southad = a1; bus.eastad = a2; bus.westad = a3;
    bus.nv_in = v[0]; bus.sv_in = v[1]; bus.ev_in = v[2]; bus.wv_in = v[3];
    bus.sb_rd = rd;
  endtask

  task automatic model_reset();
    sbq.delete();
    m_rr = 0;
    for (int p = 0; p < 4; p++) begin
      exp_ad[p] = '0;
      exp_v[p]  = 1'b0;
    end
  endtask

  task automatic model_cycle(output logic popped, output logic [FW-1:0] pop_exp);
    logic [3:0] el;
    logic       push_ok;
    exp_sel = -1;
    popped  = 1'b0;
    pop_exp = '0;
    for (int p = 0; p < 4; p++) el[p] = in_v[p] && (in_ad[p][DL +: 3] != excl(p));
    push_ok = (sbq.size() < SD) || in_rd;
    if (el != 4'b0000 && push_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (exp_sel < 0 && el[(m_rr + k) % 4]) exp_sel = (m_rr + k) % 4;
      end
    end
    if (in_rd && sbq.size() > 0) begin
      popped  = 1'b1;
      pop_exp = sbq.pop_front();
    end
    if (exp_sel >= 0) begin
      sbq.push_back(nodir(in_ad[exp_sel]));
      m_rr = (exp_sel + 1) % 4;
    end
    for (int p = 0; p < 4; p++) begin
      if (p == exp_sel) begin
        exp_v[p]  = 1'b0;
        exp_ad[p] = '0;
      end else begin
        exp_v[p]  = in_v[p];
        exp_ad[p] = in_v[p] ? nodir(in_ad[p]) : '0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in('0, '0, '0, '0, 4'b0000, 1'b0);
    model_reset();
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (o_v[p] !== 1'b0 || o_ad[p] !== '0) begin
        errors++; $display("FAIL reset_port[%0d]: got v=%b d=%h, expected v=0 d=0", p, o_v[p], o_ad[p]);
      end
    end
    checks++;
    if (bus.sb_count !== CW'(0) || bus.sb_empty !== 1'b1 || bus.sb_full !== 1'b0 || bus.sbuff !== '0) begin
      errors++; $display("FAIL reset_sb: got cnt=%0d e=%b f=%b sbuff=%h, expected 0 1 0 0", bus.sb_count, bus.sb_empty, bus.sb_full, bus.sbuff);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_excluded();
    logic popped; logic [FW-1:0] pe;
    set_in(mk(3'b010, 8'h5A), '0, '0, '0, 4'b0001, 1'b0);
    model_cycle(popped, pe);
    @(posedge clk); #1;
    checks++;
    if (bus.nv !== 1'b1 || bus.nad !== mk(3'b000, 8'h5A)) begin
      errors++; $display("FAIL excl_north: got v=%b d=%h, expected v=1 d=%h", bus.nv, bus.nad, mk(3'b000, 8'h5A));
    end
    checks++;
    if (bus.sb_count !== CW'(0) || bus.sbuff !== '0 || bus.sv !== 1'b0 || bus.ev !== 1'b0 || bus.wv !== 1'b0) begin
      errors++; $display("FAIL excl_north_sb: got cnt=%0d sbuff=%h sv/ev/wv=%b%b%b, expected 0 0 000", bus.sb_count, bus.sbuff, bus.sv, bus.ev, bus.wv);
    end
    set_in(mk(3'b010, 8'h81), mk(3'b011, 8'h82), mk(3'b000, 8'h83), mk(3'b001, 8'h84), 4'b1111, 1'b0);
    model_cycle(popped, pe);
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (o_v[p] !== 1'b1 || o_ad[p] !== mk(3'b000, 8'(8'h81 + p))) begin
        errors++; $display("FAIL excl_all[%0d]: got v=%b d=%h, expected v=1 d=%h", p, o_v[p], o_ad[p], mk(3'b000, 8'(8'h81 + p)));
      end
    end
    checks++;
    if (bus.sb_count !== CW'(0)) begin
      errors++; $display("FAIL excl_all_cnt: got %0d, expected 0", bus.sb_count);
    end
  endtask

  task automatic test_first_eject();
    logic popped; logic [FW-1:0] pe;
    set_in(mk(3'b001, 8'h11), mk(3'b000, 8'h22), mk(3'b001, 8'h33), mk(3'b000, 8'h44), 4'b1111, 1'b0);
    model_cycle(popped, pe);
    @(posedge clk); #1;
    checks++;
    if (bus.nv !== 1'b0 || bus.nad !== '0) begin
      errors++; $display("FAIL first_north: got v=%b d=%h, expected v=0 d=0", bus.nv, bus.nad);
    end
    checks++;
    if (bus.sbuff !== mk(3'b000, 8'h11) || bus.sb_count !== CW'(1) || bus.sb_empty !== 1'b0) begin
      errors++; $display("FAIL first_sb: got sbuff=%h cnt=%0d e=%b, expected %h 1 0", bus.sbuff, bus.sb_count, bus.sb_empty, mk(3'b000, 8'h11));
    end
    checks++;
    if (bus.sv !== 1'b1 || bus.sad !== mk(3'b000, 8'h22) || bus.ev !== 1'b1 || bus.ead !== mk(3'b000, 8'h33)
        || bus.wv !== 1'b1 || bus.wad !== mk(3'b000, 8'h44)) begin
      errors++; $display("FAIL first_pass: got s=%b/%h e=%b/%h w=%b/%h, expected 1/%h 1/%h 1/%h", bus.sv, bus.sad, bus.ev, bus.ead,
                         bus.wv, bus.wad, mk(3'b000, 8'h22), mk(3'b000, 8'h33), mk(3'b000, 8'h44));
    end
  endtask

  task automatic test_fill_full();
    logic popped; logic [FW-1:0] pe;
    for (int i = 0; i < 3; i++) begin
      set_in(mk(3'b000, 8'(8'h60 + i*4)), mk(3'b000, 8'(8'h61 + i*4)), mk(3'b001, 8'(8'h62 + i*4)), mk(3'b000, 8'(8'h63 + i*4)),
             4'b1111, 1'b0);
      model_cycle(popped, pe);
      @(posedge clk); #1;
      checks++;
      if (o_v[i+1] !== 1'b0 || o_ad[i+1] !== '0 || bus.sb_count !== CW'(i + 2)) begin
        errors++; $display("FAIL fill_%0d: got v=%b d=%h cnt=%0d, expected v=0 d=0 cnt=%0d", i, o_v[i+1], o_ad[i+1], bus.sb_count, i + 2);
      end
    end
    checks++;
    if (bus.sb_full !== 1'b1) begin
      errors++; $display("FAIL fill_full_flag: got %b, expected 1", bus.sb_full);
    end
    set_in(mk(3'b000, 8'h70), mk(3'b000, 8'h71), mk(3'b001, 8'h72), mk(3'b000, 8'h73), 4'b1111, 1'b0);
    model_cycle(popped, pe);
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (o_v[p] !== 1'b1 || o_ad[p] !== mk(3'b000, 8'(8'h70 + p))) begin
        errors++; $display("FAIL full_pass[%0d]: got v=%b d=%h, expected v=1 d=%h", p, o_v[p], o_ad[p], mk(3'b000, 8'(8'h70 + p)));
      end
    end
    checks++;
    if (bus.sb_count !== CW'(4) || bus.sb_full !== 1'b1 || bus.sbuff !== mk(3'b000, 8'h11)) begin
      errors++; $display("FAIL full_hold: got cnt=%0d f=%b sbuff=%h, expected 4 1 %h", bus.sb_count, bus.sb_full, bus.sbuff, mk(3'b000, 8'h11));
    end
  endtask

  task automatic test_full_pop_push();
    logic popped; logic [FW-1:0] pe;
    set_in(mk(3'b000, 8'h90), mk(3'b000, 8'h91), mk(3'b001, 8'h92), mk(3'b000, 8'h93), 4'b1111, 1'b1);
    model_cycle(popped, pe);
    checks++;
    if (!popped || bus.sbuff !== pe || bus.sbuff !== mk(3'b000, 8'h11)) begin
      errors++; $display("FAIL fullrw_head: got %h, expected %h", bus.sbuff, mk(3'b000, 8'h11));
    end
    @(posedge clk); #1;
    checks++;
    if (bus.sb_count !== CW'(4) || bus.sb_full !== 1'b1 || bus.nv !== 1'b0) begin
      errors++; $display("FAIL fullrw_cnt: got cnt=%0d f=%b nv=%b, expected 4 1 0", bus.sb_count, bus.sb_full, bus.nv);
    end
    set_in('0, '0, '0, '0, 4'b0000, 1'b1);
    for (int i = 0; i < 8 && sbq.size() > 0; i++) begin
      model_cycle(popped, pe);
      checks++;
      if (bus.sbuff !== pe) begin
        errors++; $display("FAIL drain_%0d: got %h, expected %h", i, bus.sbuff, pe);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.sb_count !== CW'(0) || bus.sb_empty !== 1'b1) begin
      errors++; $display("FAIL drain_end: got cnt=%0d e=%b, expected 0 1", bus.sb_count, bus.sb_empty);
    end
  endtask

  task automatic test_empty_read();
    logic popped; logic [FW-1:0] pe;
    set_in('0, '0, '0, '0, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      model_cycle(popped, pe);
      @(posedge clk); #1;
      checks++;
      if (bus.sb_count !== CW'(0) || bus.sbuff !== '0 || bus.sb_empty !== 1'b1 || bus.sb_full !== 1'b0) begin
        errors++; $display("FAIL empty_rd_%0d: got cnt=%0d sbuff=%h e=%b f=%b, expected 0 0 1 0", i, bus.sb_count, bus.sbuff, bus.sb_empty, bus.sb_full);
      end
    end
    set_in(mk(3'b001, 8'hAB), '0, '0, '0, 4'b0001, 1'b0);
    model_cycle(popped, pe);
    @(posedge clk); #1;
    checks++;
    if (bus.sbuff !== mk(3'b000, 8'hAB) || bus.sb_count !== CW'(1)) begin
      errors++; $display("FAIL empty_then_push: got sbuff=%h cnt=%0d, expected %h 1", bus.sbuff, bus.sb_count, mk(3'b000, 8'hAB));
    end
    set_in('0, '0, '0, '0, 4'b0000, 1'b1);
    model_cycle(popped, pe);
    checks++;
    if (!popped || bus.sbuff !== pe) begin
      errors++; $display("FAIL empty_pop: got %h, expected %h", bus.sbuff, pe);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.sb_count !== CW'(0)) begin
      errors++; $display("FAIL empty_pop_cnt: got %0d, expected 0", bus.sb_count);
    end
  endtask

  task automatic test_random();
    logic popped; logic [FW-1:0] pe; logic [FW-1:0] head;
    logic [FW-1:0] a [4];
    logic [3:0] v;
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < 4; p++) a[p] = mk(3'($urandom_range(0, 7)), 8'($urandom));
      v = 4'($urandom);
      set_in(a[0], a[1], a[2], a[3], v, ($urandom_range(0, 2) == 0));
      model_cycle(popped, pe);
      if (popped) begin
        checks++;
        if (bus.sbuff !== pe) begin
          errors++; $display("FAIL rnd_pop@%0d: got %h, expected %h", n, bus.sbuff, pe);
        end
      end
      @(posedge clk); #1;
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (o_v[p] !== exp_v[p] || o_ad[p] !== exp_ad[p]) begin
          errors++; $display("FAIL rnd_port[%0d]@%0d: got v=%b d=%h, expected v=%b d=%h", p, n, o_v[p], o_ad[p], exp_v[p], exp_ad[p]);
        end
      end
      head = (sbq.size() > 0) ? sbq[0] : '0;
      checks++;
      if (bus.sb_count !== CW'(sbq.size()) || bus.sbuff !== head || bus.sb_full !== (sbq.size() == SD)
          || bus.sb_empty !== (sbq.size() == 0)) begin
        errors++; $display("FAIL rnd_sb@%0d: got cnt=%0d sbuff=%h f=%b e=%b, expected cnt=%0d sbuff=%h", n, bus.sb_count, bus.sbuff,
                           bus.sb_full, bus.sb_empty, sbq.size(), head);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic popped; logic [FW-1:0] pe;
    rst_n = 1'b0;
    set_in('0, '0, '0, '0, 4'b0000, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(mk(3'b000, 8'(8'hC0 + i*4)), mk(3'b000, 8'(8'hC1 + i*4)), mk(3'b001, 8'(8'hC2 + i*4)), mk(3'b000, 8'(8'hC3 + i*4)),
             4'b1111, 1'b0);
      model_cycle(popped, pe);
      @(posedge clk); #1;
    end
    set_in(mk(3'b010, 8'hD1), mk(3'b011, 8'hD2), mk(3'b000, 8'hD3), mk(3'b001, 8'hD4), 4'b1111, 1'b0);
    model_cycle(popped, pe);
    @(posedge clk); #1;
    checks++;
    if (bus.sb_count !== CW'(3) || bus.nv !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got cnt=%0d nv=%b, expected 3 1", bus.sb_count, bus.nv);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (o_v[p] !== 1'b0 || o_ad[p] !== '0) begin
        errors++; $display("FAIL midrst_port[%0d]: got v=%b d=%h, expected v=0 d=0", p, o_v[p], o_ad[p]);
      end
    end
    checks++;
    if (bus.sb_count !== CW'(0) || bus.sb_empty !== 1'b1 || bus.sbuff !== '0) begin
      errors++; $display("FAIL midrst_sb: got cnt=%0d e=%b sbuff=%h, expected 0 1 0", bus.sb_count, bus.sb_empty, bus.sbuff);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_in(mk(3'b001, 8'hE0), mk(3'b000, 8'hE1), mk(3'b001, 8'hE2), mk(3'b000, 8'hE3), 4'b1111, 1'b0);
    model_cycle(popped, pe);
    @(posedge clk); #1;
    checks++;
    if (bus.nv !== 1'b0 || bus.wv !== 1'b1 || bus.sbuff !== mk(3'b000, 8'hE0) || bus.sb_count !== CW'(1)) begin
      errors++; $display("FAIL postrst_eject: got nv=%b wv=%b sbuff=%h cnt=%0d, expected 0 1 %h 1", bus.nv, bus.wv, bus.sbuff,
                         bus.sb_count, mk(3'b000, 8'hE0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_excluded();
    test_first_eject();
    test_fill_full();
    test_full_pop_push();
    test_empty_read();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/buff_eject_sb.md
BUFF_EJECT_SB -- requirements
Module: buff_eject_sb

Interface
REQ-001 SHALL have parameter FLIT_W, default 11: flit width in bits.
REQ-002 SHALL have parameter DIR_LSB, default 6: LSB of the 3-bit direction field, field [DIR_LSB+2:DIR_LSB].
REQ-003 SHALL have parameter SB_DEPTH, default 4, power of two >= 2: side-buffer entries.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have ports northad, southad, eastad, westad, input, FLIT_W each: incoming flits.
REQ-007 SHALL have ports nv_in, sv_in, ev_in, wv_in, input, 1 each: valid for the matching flit.
REQ-008 SHALL have ports nad, sad, ead, wad, output, FLIT_W each: registered outgoing flits.
REQ-009 SHALL have ports nv, sv, ev, wv, output, 1 each: valid for the matching output.
REQ-010 SHALL have port sb_rd, input, 1: pop request for the side buffer.
REQ-011 SHALL have port sbuff, output, FLIT_W: side-buffer head flit, 0 when empty.
REQ-012 SHALL have ports sb_empty, sb_full, output, 1 each, and sb_count, output, $clog2(SB_DEPTH)+1: occupancy.

Function
REQ-013 SHALL treat a port as ineligible when its valid is low or its direction field equals the port's exclusion code: north 3'b010, south 3'b011, east 3'b000, west 3'b001.
REQ-014 SHALL eject at most one flit per cycle, and only when at least one port is eligible and push space exists (REQ-020).
REQ-015 SHALL choose the ejected port as the first eligible port scanning N,S,E,W cyclically from start index sel_start (2 bits).
REQ-016 SHALL write the ejected flit into the side buffer with its direction field forced to 3'b000, and drive that port's registered valid to 0 next cycle.
REQ-017 SHALL register every non-ejected port next cycle with its direction field forced to 3'b000, all other bits unchanged, and valid equal to its input valid; latency is 1 cycle.
REQ-018 SHALL drive invalid output flits to all zeros.
REQ-019 SHALL implement the side buffer as a FIFO with wrapping read/write pointers; sbuff shows the head combinationally from storage.
REQ-020 SHALL accept a push when not full, or when full and sb_rd is high in the same cycle (pop first, count unchanged).
REQ-021 SHALL ignore sb_rd when empty, with no pointer or count change.
REQ-022 SHALL, on simultaneous push and pop when not empty, keep sb_count unchanged and advance both pointers.
REQ-023 SHALL, when no eject occurs, pass all four ports through per REQ-017.

Reset
REQ-024 SHALL, while rst_n is low, asynchronously clear all outputs to 0, valids to 0, both pointers and sb_count to 0, set sb_empty to 1, and set sel_start to 0 (LFSR to 8'h01).
REQ-025 SHALL discard buffered flits on a mid-operation reset; the first eject after release uses start index 0 (round-robin build) or the seed-derived index (LFSR build).

Configuration
REQ-026 SHALL, with BUFF_EJECT_LFSR_EN defined, derive sel_start from bits [1:0] of an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'h01) that advances every cycle.
REQ-027 SHALL, without BUFF_EJECT_LFSR_EN, derive sel_start from a round-robin pointer set to (ejected port index + 1) mod 4 after each eject, held otherwise.

Verification
REQ-028 SHALL cover: all valid, dirs N=001 S=000 E=001 W=000, RR build after reset -> north ejected, sbuff dir field 0, nv=0, sb_count=1.
REQ-029 SHALL cover: only north valid with dir 3'b010 -> no eject, nad=north flit with dir 0, nv=1, sb_count=0.
REQ-030 SHALL cover: SB_DEPTH=4, 4 eligible ejects -> sb_full=1, fifth eligible cycle without sb_rd -> no eject, all four pass.
REQ-031 SHALL cover: full buffer, sb_rd=1 with an eligible port -> pop and push same cycle, sb_count stays 4, FIFO order preserved.
REQ-032 SHALL cover: sb_rd=1 while empty -> sb_count=0, sbuff=0, no underflow.
REQ-033 SHALL cover: rst_n low mid-stream with 3 entries -> outputs and sb_count 0 immediately, no clock needed.
